// File: rtl/seq_mem_cam_param_1s1w1i_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_mem_cam_param_1s1w1i_pkg
// Purpose : Shared defaults for the parametrised 1-search/1-write/1-invalidate
//           CAM. The entry-index width is derived locally in each module from
//           the entry count, so only the default geometry lives here.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package seq_mem_cam_param_1s1w1i_pkg;

    localparam int CAM_DEF_ENTRIES = 8;
    localparam int CAM_DEF_DATA_W  = 8;

endpackage : seq_mem_cam_param_1s1w1i_pkg
`default_nettype wire

// File: rtl/seq_mem_cam_param_1s1w1i_cam_prio_enc.sv
`default_nettype none
// ============================================================================
// Module  : cam_prio_enc
// Purpose : Priority encoder. Reports the index of the lowest-numbered set bit
//           of a request vector, plus an any-bit-set flag. The index is 0 when
//           no bit is set.
// Ports   : i_vec  [N-1:0]  request / match vector
//           o_idx  [W-1:0]  lowest set-bit index (0 if none)
//           o_hit           OR of i_vec
// Rev     : 1.0  initial release
// ============================================================================
module cam_prio_enc #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    output logic [W-1:0] o_idx,
    output logic         o_hit
);

    // Scan from the top down so a lower-numbered set bit overwrites any
    // higher one: the last assignment made is the lowest match.
    always_comb begin
        o_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = W'(i);
            end
        end
        o_hit = |i_vec;
    end

endmodule : cam_prio_enc
`default_nettype wire

// File: rtl/seq_mem_cam_param_1s1w1i.sv
`default_nettype none
// ============================================================================
// Module  : seq_mem_cam_param_1s1w1i
// Purpose : Parametrised CAM with one write port, one invalidate port, a
//           flush, and one ternary (masked) search port. Search results are
//           registered; the hit index is the lowest matching entry.
// Ports   : clk, reset                   clock / synchronous active-high reset
//           write_en/addr/data           write data and set valid
//           inval_en/addr                clear one valid bit
//           flush                        clear all valid bits
//           search_en/data/mask          masked search (mask bit 1 = compare)
//           search_match [NUM_ENTRIES]   registered per-entry match vector
//           search_hit                   registered OR of search_match
//           search_idx   [ADDR_W]        registered lowest matching index
// Rev     : 1.0  initial release
// ============================================================================
module seq_mem_cam_param_1s1w1i
    import seq_mem_cam_param_1s1w1i_pkg::*;
#(
    parameter  int NUM_ENTRIES = CAM_DEF_ENTRIES,
    parameter  int DATA_W      = CAM_DEF_DATA_W,
    localparam int ADDR_W      = $clog2(NUM_ENTRIES)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   write_en,
    input  logic [ADDR_W-1:0]      write_addr,
    input  logic [DATA_W-1:0]      write_data,
    input  logic                   inval_en,
    input  logic [ADDR_W-1:0]      inval_addr,
    input  logic                   flush,
    input  logic                   search_en,
    input  logic [DATA_W-1:0]      search_data,
    input  logic [DATA_W-1:0]      search_mask,
    output logic [NUM_ENTRIES-1:0] search_match,
    output logic                   search_hit,
    output logic [ADDR_W-1:0]      search_idx
);

    logic [DATA_W-1:0]      r_data [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] r_valid;

    logic [NUM_ENTRIES-1:0] w_match;
    logic [ADDR_W-1:0]      w_idx;
    logic                   w_hit;

    // Data array has no reset: contents are meaningless while invalid.
    // A write coinciding with flush still lands in the array.
    always_ff @(posedge clk) begin
        if (!reset && write_en) begin
            r_data[write_addr] <= write_data;
        end
    end

    // Valid bits, per-entry priority: reset > flush > write > invalidate.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                if (flush) begin
                    r_valid[i] <= 1'b0;
                end else if (write_en && (write_addr == ADDR_W'(i))) begin
                    r_valid[i] <= 1'b1;
                end else if (inval_en && (inval_addr == ADDR_W'(i))) begin
                    r_valid[i] <= 1'b0;
                end
            end
        end
    end

    // Compare against pre-edge array state, so same-cycle updates are never
    // forwarded into the current search.
    generate
        for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_cmp
            assign w_match[g] = r_valid[g] &&
                                (((r_data[g] ^ search_data) & search_mask) == '0);
        end
    endgenerate

    cam_prio_enc #(
        .N (NUM_ENTRIES)
    ) u_prio_enc (
        .i_vec (w_match),
        .o_idx (w_idx),
        .o_hit (w_hit)
    );

    // Outputs reflect only the search of the previous cycle; an idle cycle
    // clears them.
    always_ff @(posedge clk) begin
        if (reset || !search_en) begin
            search_match <= '0;
            search_hit   <= 1'b0;
            search_idx   <= '0;
        end else begin
            search_match <= w_match;
            search_hit   <= w_hit;
            search_idx   <= w_idx;
        end
    end

endmodule : seq_mem_cam_param_1s1w1i
`default_nettype wire

// File: tb/tb_seq_mem_cam_param_1s1w1i.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_mem_cam_param_1s1w1i
// Purpose : Self-checking bench for seq_mem_cam_param_1s1w1i. Drives an 8x8
//           and a 16x12 instance with shared stimulus; a directed vector
//           table exercises the 8x8 instance, and both instances are compared
//           every cycle against an array-based reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_seq_mem_cam_param_1s1w1i;

    logic        clk = 1'b0;
    logic        reset;
    logic        we, ie, fl, se;
    logic [3:0]  wa, ia;
    logic [11:0] wd, sd, sm;

    logic [7:0]  match8;
    logic        hit8;
    logic [2:0]  idx8;
    logic [15:0] match16;
    logic        hit16;
    logic [3:0]  idx16;

    always #5 clk = ~clk;

    seq_mem_cam_param_1s1w1i #(.NUM_ENTRIES(8), .DATA_W(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .write_en     (we),
        .write_addr   (wa[2:0]),
        .write_data   (wd[7:0]),
        .inval_en     (ie),
        .inval_addr   (ia[2:0]),
        .flush        (fl),
        .search_en    (se),
        .search_data  (sd[7:0]),
        .search_mask  (sm[7:0]),
        .search_match (match8),
        .search_hit   (hit8),
        .search_idx   (idx8)
    );

    seq_mem_cam_param_1s1w1i #(.NUM_ENTRIES(16), .DATA_W(12)) dut16 (
        .clk          (clk),
        .reset        (reset),
        .write_en     (we),
        .write_addr   (wa),
        .write_data   (wd),
        .inval_en     (ie),
        .inval_addr   (ia),
        .flush        (fl),
        .search_en    (se),
        .search_data  (sd),
        .search_mask  (sm),
        .search_match (match16),
        .search_hit   (hit16),
        .search_idx   (idx16)
    );

    int errors = 0;
    int checks = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // Reference model: [0] = 8 entries x 8 bits, [1] = 16 entries x 12 bits.
    logic [11:0] mdata  [2][16];
    bit          mvalid [2][16];

    task automatic step(input string tag, input bit r_i, input bit we_i,
                        input logic [3:0] wa_i, input logic [11:0] wd_i,
                        input bit ie_i, input logic [3:0] ia_i, input bit fl_i,
                        input bit se_i, input logic [11:0] sd_i,
                        input logic [11:0] sm_i);
        logic [15:0] em [2];
        int          ei [2];
        int          n;
        logic [11:0] msk;
        logic [3:0]  a_w, a_i;
        reset = r_i; we = we_i; wa = wa_i; wd = wd_i;
        ie = ie_i; ia = ia_i; fl = fl_i; se = se_i; sd = sd_i; sm = sm_i;
        // Expected result from model state before this edge.
        for (int m = 0; m < 2; m++) begin
            n   = (m == 0) ? 8 : 16;
            msk = (m == 0) ? 12'h0FF : 12'hFFF;
            em[m] = '0;
            ei[m] = 0;
            if (!r_i && se_i) begin
                for (int e = 0; e < n; e++) begin
                    if (mvalid[m][e] && (((mdata[m][e] ^ sd_i) & sm_i & msk) == 12'h0))
                        em[m][e] = 1'b1;
                end
            end
            for (int e = n - 1; e >= 0; e--) begin
                if (em[m][e]) ei[m] = e;
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "/m8_match"},  32'(match8),  32'(em[0][7:0]));
        chk({tag, "/m8_hit"},    32'(hit8),    32'(em[0] != 0));
        chk({tag, "/m8_idx"},    32'(idx8),    32'(ei[0]));
        chk({tag, "/m16_match"}, 32'(match16), 32'(em[1]));
        chk({tag, "/m16_hit"},   32'(hit16),   32'(em[1] != 0));
        chk({tag, "/m16_idx"},   32'(idx16),   32'(ei[1]));
        // Advance the model.
        for (int m = 0; m < 2; m++) begin
            n   = (m == 0) ? 8 : 16;
            msk = (m == 0) ? 12'h0FF : 12'hFFF;
            a_w = wa_i & 4'(n - 1);
            a_i = ia_i & 4'(n - 1);
            if (r_i) begin
                for (int e = 0; e < 16; e++) mvalid[m][e] = 0;
            end else begin
                if (we_i) mdata[m][a_w] = wd_i & msk;
                if (fl_i) begin
                    for (int e = 0; e < 16; e++) mvalid[m][e] = 0;
                end else if (we_i) begin
                    mvalid[m][a_w] = 1;
                    if (ie_i && a_i != a_w) mvalid[m][a_i] = 0;
                end else if (ie_i) begin
                    mvalid[m][a_i] = 0;
                end
            end
        end
    endtask

    typedef struct {
        bit          r;
        bit          we;
        logic [3:0]  wa;
        logic [11:0] wd;
        bit          ie;
        logic [3:0]  ia;
        bit          fl;
        bit          se;
        logic [11:0] sd;
        logic [11:0] sm;
        logic [7:0]  em;
        bit          eh;
        logic [2:0]  ei;
    } vec_t;

    function automatic vec_t mk(bit r, bit we_i, logic [3:0] wa_i, logic [11:0] wd_i,
                                bit ie_i, logic [3:0] ia_i, bit fl_i, bit se_i,
                                logic [11:0] sd_i, logic [11:0] sm_i,
                                logic [7:0] em, bit eh, logic [2:0] ei);
        vec_t v;
        v.r = r; v.we = we_i; v.wa = wa_i; v.wd = wd_i; v.ie = ie_i; v.ia = ia_i;
        v.fl = fl_i; v.se = se_i; v.sd = sd_i; v.sm = sm_i;
        v.em = em; v.eh = eh; v.ei = ei;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        for (int m = 0; m < 2; m++)
            for (int e = 0; e < 16; e++) begin
                mdata[m][e]  = 12'h0;
                mvalid[m][e] = 0;
            end

        //                 r we wa  wd     ie ia fl se sd      sm      em     eh ei
        tbl.push_back(mk(1, 0, 0, 12'h00, 0, 0, 0, 1, 12'h00, 12'hFF, 8'h00, 0, 0)); // reset + search
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h00, 12'hFF, 8'h00, 0, 0)); // all invalid
        tbl.push_back(mk(0, 1, 3, 12'hAB, 0, 0, 0, 0, 12'h00, 12'hFF, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'hAB, 12'hFF, 8'h08, 1, 3)); // latency
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 0, 12'hAB, 12'hFF, 8'h00, 0, 0)); // idle clears
        tbl.push_back(mk(0, 1, 5, 12'h5A, 0, 0, 0, 1, 12'h5A, 12'hFF, 8'h00, 0, 0)); // no forward
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h5A, 12'hFF, 8'h20, 1, 5));
        tbl.push_back(mk(0, 1, 1, 12'h23, 0, 0, 0, 0, 12'h00, 12'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 4, 12'h23, 0, 0, 0, 0, 12'h00, 12'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 6, 12'h23, 0, 0, 0, 0, 12'h00, 12'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 2, 12'h2F, 0, 0, 0, 0, 12'h00, 12'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h23, 12'hFF, 8'h52, 1, 1)); // multi-match
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h20, 12'hF0, 8'h56, 1, 1)); // masked
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'hC3, 12'h00, 8'h7E, 1, 1)); // mask 0
        tbl.push_back(mk(0, 1, 2, 12'h77, 1, 2, 0, 0, 12'h00, 12'hFF, 8'h00, 0, 0)); // write+inval
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h77, 12'hFF, 8'h04, 1, 2));
        tbl.push_back(mk(0, 0, 0, 12'h00, 1, 2, 0, 0, 12'h00, 12'hFF, 8'h00, 0, 0)); // inval alone
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h77, 12'hFF, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 0, 12'h99, 0, 0, 1, 1, 12'h23, 12'hFF, 8'h52, 1, 1)); // flush+write, search pre-state
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h99, 12'hFF, 8'h00, 0, 0));
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h00, 12'h00, 8'h00, 0, 0));
        tbl.push_back(mk(0, 1, 7, 12'h11, 0, 0, 0, 0, 12'h00, 12'hFF, 8'h00, 0, 0));
        tbl.push_back(mk(1, 0, 0, 12'h00, 0, 0, 0, 1, 12'h11, 12'hFF, 8'h00, 0, 0)); // reset beats search
        tbl.push_back(mk(0, 0, 0, 12'h00, 0, 0, 0, 1, 12'h11, 12'hFF, 8'h00, 0, 0)); // reset cleared valid

        foreach (tbl[k]) begin
            vec_t v;
            string t;
            v = tbl[k];
            t = $sformatf("v%0d", k);
            step(t, v.r, v.we, v.wa, v.wd, v.ie, v.ia, v.fl, v.se, v.sd, v.sm);
            chk({t, "/tbl_match"}, 32'(match8), 32'(v.em));
            chk({t, "/tbl_hit"},   32'(hit8),   32'(v.eh));
            chk({t, "/tbl_idx"},   32'(idx8),   32'(v.ei));
        end

        for (int c = 0; c < 200; c++) begin
            step($sformatf("rnd%0d", c),
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)),
                 12'($urandom_range(0, 3)),
                 $urandom_range(0, 2) == 0,
                 4'($urandom_range(0, 15)),
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0,
                 12'($urandom_range(0, 3)),
                 12'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_seq_mem_cam_param_1s1w1i
`default_nettype wire

// File: doc/seq_mem_cam_param_1s1w1i.md
Name: seq_mem_cam_param_1s1w1i

Overview:
Parametrised content-addressable memory with one write port, one invalidate port and one masked search port.
- Successor to the fixed 8x8b single-search CAM.
- Adds per-entry valid bits, an explicit invalidate, a flush, and ternary (masked) compare.
- Search result is registered, with a priority-encoded hit index.
- Sits beside tag/lookup structures (TLB-like, scoreboard lookups) in the sequential-memory problem family.

Parameters:
- NUM_ENTRIES, 8, number of CAM entries (>= 2, power of two).
- DATA_W, 8, width of each stored word and of the search key.
- ADDR_W, $clog2(NUM_ENTRIES), derived entry-index width; not overridden by the user.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- write_en  input  1  write write_data into entry write_addr and set its valid bit.
- write_addr  input  ADDR_W  entry index for write.
- write_data  input  DATA_W  data to store.
- inval_en  input  1  clear the valid bit of entry inval_addr.
- inval_addr  input  ADDR_W  entry index for invalidate.
- flush  input  1  clear all valid bits.
- search_en  input  1  perform a search this cycle.
- search_data  input  DATA_W  search key.
- search_mask  input  DATA_W  per-bit compare enable; 1 = compare this bit, 0 = don't care.
- search_match  output  NUM_ENTRIES  registered one-hot-per-entry match vector.
- search_hit  output  1  registered OR of search_match.
- search_idx  output  ADDR_W  registered index of the lowest-numbered matching entry; 0 when no hit.

Behaviour:
- Storage: NUM_ENTRIES x DATA_W data array plus a NUM_ENTRIES valid vector.
- Reset:
  - Valid vector goes to all 0.
  - search_match, search_hit and search_idx go to 0 on the cycle after reset is sampled.
  - Data array is not cleared; its contents are don't-care while invalid.
  - Reset has priority over every other input, including mid-search: a search presented in the reset cycle produces 0 outputs.
- Match, entry i: valid[i] && ((stored[i] ^ search_data) & search_mask) == 0.
  - An all-zero mask matches every valid entry.
  - An invalid entry never matches.
- Latency:
  - The search samples array state as it is before the rising edge that ends cycle N.
  - The result is registered at that edge and is visible for all of cycle N+1.
  - Outputs hold until the next edge; they are not sticky across cycles.
- search_en low at an edge: all three outputs go to 0 after that edge.
- No forwarding: a write, invalidate or flush in the same cycle as a search does not affect that search's result. It takes effect for searches in later cycles.
- Update priority per entry, highest first: reset, flush, write, invalidate.
  - Write and invalidate to the same address in the same cycle: the entry ends valid with the new data.
  - Flush together with write: all entries invalid, but the write data is still stored in the array.
- Write to an already-valid entry overwrites the data; the entry stays valid.
- Duplicate values are allowed. Multiple matches set multiple bits in search_match; search_idx reports the lowest index.
- Address range: full range 0..NUM_ENTRIES-1; no out-of-range case because NUM_ENTRIES is a power of two.
- Implementation:
  - Purely synchronous; no latches.
  - Compare logic is combinational into the output register.
  - Priority encoder is a for-loop scanning from the highest index down to index 0, so the lowest match wins.

Decomposition:
- Shared package: none required; ADDR_W is derived locally.
- One sub-module: cam_prio_enc (NUM_ENTRIES -> ADDR_W index + hit). It is reusable by later arbiter/CAM blocks and is instantiated between the compare vector and the output register.

Test Plan:
- Reset-then-idle: reset, search_en=1, key 0x00, mask 0xFF -> match 0x00, hit 0 (all entries invalid despite stale data).
- Write/search latency:
  - Cycle 0: write addr 3 = 0xAB.
  - Cycle 1: search 0xAB, mask 0xFF.
  - Cycle 2: match 0x08, hit 1, idx 3.
  - Also in cycle 2: search_en=0 -> cycle 3 all outputs 0.
- No-forward:
  - Same cycle: write addr 5 = 0x5A and search 0x5A -> next cycle hit 0.
  - Repeat the search -> match 0x20, idx 5.
- Multi-match and masking:
  - Entries 1, 4, 6 = 0x23; entry 2 = 0x2F.
  - Search 0x23, mask 0xFF -> match 0x52, idx 1.
  - Search 0x20, mask 0xF0 -> match 0x56, idx 1.
  - Mask 0x00 -> every valid entry matches.
- Invalidate/flush priority:
  - Write 0x77 and invalidate addr 2 in the same cycle -> later search 0x77 hits, idx 2.
  - Invalidate addr 2 alone -> later search misses.
  - flush with write addr 0 -> all later searches miss.
- Random: 200 cycles of random enables, addresses, 2-bit-range data and random masks, compared against a behavioural model. Repeat with NUM_ENTRIES=16, DATA_W=12.
